y86_fetch_decode_execute: RTL and testbench
===========================================

// Module: y86_fetch_decode_execute
// PURPOSE
//  Combined fetch/decode/execute front end of the sequential Y86-64 CPU. Fetches and parses one
//  instruction at PC from an internal byte-wide instruction memory. Reads/writes the 15-entry
//  register file, computes valE and the branch/cmov condition, and holds the condition codes.
//  The external memory and PC-update stages supply valM and drive PC.
// PARAMETERS
//  IMEM_BYTES  1024  instruction memory size in bytes; addresses >= IMEM_BYTES are out of range
// PORTS
//  clk          in   1     single clock; all state updates on posedge
//  rst_n        in   1     reset, synchronous, active-low
//  imem_we      in   1     instruction memory byte write enable (program load)
//  imem_waddr   in   64    load address
//  imem_wdata   in   8     load byte
//  PC           in   64    current program counter
//  valM         in   64    memory-stage read data, used for write-back
//  icode        out  4     byte0[7:4]
//  ifun         out  4     byte0[3:0]
//  rA           out  4     byte1[7:4] (4'hF when the instruction has no register byte)
//  rB           out  4     byte1[3:0] (4'hF when the instruction has no register byte)
//  valC         out  64    constant word, little-endian
//  valP         out  64    PC + instruction length
//  instr_valid  out  1     1 = icode in 0..B
//  imem_error   out  1     1 = some fetched byte address >= IMEM_BYTES
//  hlt          out  1     1 = icode 0
//  valA         out  64    register read A (0 when srcA=F)
//  valB         out  64    register read B (0 when srcB=F)
//  valE         out  64    ALU result
//  cond         out  1     condition result for jXX/cmovXX
//  overflow     out  1     OF of the current OPq computation (combinational)
//  cc           out  3     condition code register {ZF,SF,OF}
//  regs_flat    out  960   register file; reg i at [64*i+63:64*i]
// BEHAVIOUR
//  - Fetch, decode, execute and all outputs except cc/regs_flat are combinational from PC,
//    memory contents, register file and cc.
//  - Instruction lengths: 0 halt=1, 1 nop=1, 2 cmov=2, 3 irmovq=10, 4 rmmovq=10,
//    5 mrmovq=10, 6 OPq=2, 7 jXX=9, 8 call=9, 9 ret=1, A pushq=2, B popq=2.
//  - valC location: bytes 2..9 for icode 3/4/5; bytes 1..8 for icode 7/8; otherwise 0.
//  - Invalid icode (C..F): instr_valid=0 and valP=PC+1.
//  - imem_error: some fetched byte is out of range. Out-of-range bytes read as 0.
//  - srcA: rA for 2,4,6,A; reg 4 (rsp) for 9,B; else F.
//  - srcB: rB for 4,5,6; rsp for 8,9,A,B; else F.
//  - valE:
//    - 2: 0+valA.
//    - 3: 0+valC.
//    - 4,5: valB+valC.
//    - 6: by ifun: 0 add valB+valA, 1 sub valB-valA, 2 and, 3 xor.
//    - 8,A: valB-8.
//    - 9,B: valB+8.
//    - others: 0.
//    - All arithmetic is 64-bit, wraps modulo 2^64.
//  - Flags (OPq): ZF=(valE==0), SF=valE[63].
//    - OF for add: same-sign operands and result sign differs.
//    - OF for sub: signs of valA/valB differ and result sign differs from valB.
//    - OF for logical ops: 0.
//  - cond from cc by ifun: 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF);
//    6 g ~(SF^OF)&~ZF; 7..F 0. cond=0 for icodes other than 2,7.
//  - Posedge, rst_n=0: all 15 registers <= 0; cc <= 3'b100. No write-back. imem is unaffected.
//  - Posedge, rst_n=1:
//    - Condition codes: if icode==6 && instr_valid, cc <= {ZF,SF,OF}.
//    - E write-back: dstE <= valE. dstE = rB for 3, 6, or 2 when cond; rsp for 8,9,A,B.
//    - M write-back: dstM <= valM. dstM = rA for 5,B.
//    - If dstE==dstM, the M write wins.
//    - No writes when dst=F, when hlt, when instr_valid=0, or when imem_error.
//  - imem_we writes a byte at posedge regardless of rst_n; out-of-range writes are ignored.
// TESTING
//  - Reset: rst_n=0 for 1 clk -> regs_flat=0, cc=3'b100; with PC=0 over nop (0x10): valP=1, hlt=0.
//  - irmovq: bytes 30 F2 0A 00.. at PC=0 -> icode=3, rB=2, valC=10, valP=10, valE=10;
//    after clk, reg2=10.
//  - OPq: reg2=10, reg3=3; 61 23 (subq %rdx,%rbx) -> valE=3-10=-7; after clk reg3=-7,
//    cc={0,1,0}; then jl (72) -> cond=1, jle=1, je=0.
//  - Overflow: reg0=2^63-1, reg1=1, 60 01 -> valE=2^63, overflow=1; after clk cc={0,1,1}.
//  - Stack: rsp=0x100, pushq A0 2F -> valE=0xF8; after clk rsp=0xF8.
//    popq B0 4F with valM=0x55 -> dstM=rsp wins, rsp=0x55.
//  - Status: byte 00 -> hlt=1, no write. Byte C0 -> instr_valid=0, valP=PC+1.
//    PC=IMEM_BYTES-2 on irmovq -> imem_error=1, no register change.

Source files
------------

// File: rtl/y86_fetch_decode_execute_if.sv
// Bus bundle for the Y86-64 fetch/decode/execute front end: program-load port,
// PC/valM inputs from the later stages, and every decoded/executed result.
interface y86_fetch_decode_execute_if;
  logic         imem_we;
  logic [63:0]  imem_waddr;
  logic [7:0]   imem_wdata;
  logic [63:0]  PC;
  logic [63:0]  valM;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [3:0]   rA;
  logic [3:0]   rB;
  logic [63:0]  valC;
  logic [63:0]  valP;
  logic         instr_valid;
  logic         imem_error;
  logic         hlt;
  logic [63:0]  valA;
  logic [63:0]  valB;
  logic [63:0]  valE;
  logic         cond;
  logic         overflow;
  logic [2:0]   cc;
  logic [959:0] regs_flat;

  modport master (
    output imem_we, imem_waddr, imem_wdata, PC, valM,
    input  icode, ifun, rA, rB, valC, valP, instr_valid, imem_error, hlt,
           valA, valB, valE, cond, overflow, cc, regs_flat
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, PC, valM,
    output icode, ifun, rA, rB, valC, valP, instr_valid, imem_error, hlt,
           valA, valB, valE, cond, overflow, cc, regs_flat
  );
endinterface

// File: rtl/y86_fetch_decode_execute.sv
// Sequential Y86-64 fetch/decode/execute front end.
// Fetch, decode and execute are purely combinational from PC, instruction memory,
// register file and condition codes; the register file and CC update on posedge.
module y86_fetch_decode_execute #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  y86_fetch_decode_execute_if.slave bus
);

  localparam int          AW         = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
  localparam logic [3:0]  RNONE      = 4'hF;
  localparam logic [3:0]  RSP        = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  // valC placement selector
  localparam logic [1:0] VC_NONE  = 2'd0;
  localparam logic [1:0] VC_AT1   = 2'd1;
  localparam logic [1:0] VC_AT2   = 2'd2;

  logic [7:0]   imem_q [IMEM_BYTES];
  logic [63:0]  regs_q [15];
  logic [63:0]  regs_d [15];
  logic [2:0]   cc_q;
  logic [2:0]   cc_d;

  logic [63:0]  fetch_addr_s [10];
  logic [7:0]   fbyte_s [10];
  logic [9:0]   foob_s;
  logic [3:0]   icode_s;
  logic [3:0]   ifun_s;
  logic [3:0]   len_s;
  logic         need_reg_s;
  logic [1:0]   valc_sel_s;
  logic         valid_s;
  logic         imem_err_s;
  logic [3:0]   ra_s;
  logic [3:0]   rb_s;
  logic [63:0]  valc_s;
  logic [3:0]   src_a_s;
  logic [3:0]   src_b_s;
  logic [63:0]  val_a_s;
  logic [63:0]  val_b_s;
  logic [63:0]  val_e_s;
  logic         ovf_s;
  logic         zf_s;
  logic         sf_s;
  logic         cond_s;
  logic [3:0]   dst_e_s;
  logic [3:0]   dst_m_s;
  logic         wb_ok_s;
  logic [959:0] regs_flat_s;

  // Program load port: byte writes, independent of reset, out-of-range ignored
  always_ff @(posedge clk) begin
    if (bus.imem_we && (bus.imem_waddr < IMEM_LIMIT)) begin
      imem_q[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
    end
  end

  // Fetch the ten bytes starting at PC; out-of-range bytes read as zero and are flagged
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      fetch_addr_s[k] = bus.PC + 64'(k);
      if (fetch_addr_s[k] < IMEM_LIMIT) begin
        fbyte_s[k] = imem_q[fetch_addr_s[k][AW-1:0]];
        foob_s[k]  = 1'b0;
      end else begin
        fbyte_s[k] = 8'h00;
        foob_s[k]  = 1'b1;
      end
    end
  end

  assign icode_s = fbyte_s[0][7:4];
  assign ifun_s  = fbyte_s[0][3:0];

  // Instruction format: length, register byte presence, constant placement, validity
  always_comb begin
    len_s      = 4'd1;
    need_reg_s = 1'b0;
    valc_sel_s = VC_NONE;
    valid_s    = 1'b1;
    case (icode_s)
      I_HALT, I_NOP, I_RET: begin
        len_s = 4'd1;
      end
      I_CMOV, I_OPQ, I_PUSH, I_POP: begin
        len_s      = 4'd2;
        need_reg_s = 1'b1;
      end
      I_IRMOV, I_RMMOV, I_MRMOV: begin
        len_s      = 4'd10;
        need_reg_s = 1'b1;
        valc_sel_s = VC_AT2;
      end
      I_JXX, I_CALL: begin
        len_s      = 4'd9;
        valc_sel_s = VC_AT1;
      end
      default: begin
        len_s   = 4'd1;
        valid_s = 1'b0;
      end
    endcase
  end

  // Memory error only counts bytes that the instruction actually occupies
  always_comb begin
    imem_err_s = 1'b0;
    for (int k = 0; k < 10; k++) begin
      imem_err_s = imem_err_s | (foob_s[k] & (4'(k) < len_s));
    end
  end

  assign ra_s = need_reg_s ? fbyte_s[1][7:4] : RNONE;
  assign rb_s = need_reg_s ? fbyte_s[1][3:0] : RNONE;

  // Little-endian constant word extraction
  always_comb begin
    case (valc_sel_s)
      VC_AT1:  valc_s = {fbyte_s[8], fbyte_s[7], fbyte_s[6], fbyte_s[5],
                         fbyte_s[4], fbyte_s[3], fbyte_s[2], fbyte_s[1]};
      VC_AT2:  valc_s = {fbyte_s[9], fbyte_s[8], fbyte_s[7], fbyte_s[6],
                         fbyte_s[5], fbyte_s[4], fbyte_s[3], fbyte_s[2]};
      default: valc_s = 64'd0;
    endcase
  end

  // Register source selection
  always_comb begin
    case (icode_s)
      I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src_a_s = ra_s;
      I_RET, I_POP:                   src_a_s = RSP;
      default:                        src_a_s = RNONE;
    endcase
    case (icode_s)
      I_RMMOV, I_MRMOV, I_OPQ:         src_b_s = rb_s;
      I_CALL, I_RET, I_PUSH, I_POP:    src_b_s = RSP;
      default:                         src_b_s = RNONE;
    endcase
  end

  assign val_a_s = (src_a_s == RNONE) ? 64'd0 : regs_q[src_a_s];
  assign val_b_s = (src_b_s == RNONE) ? 64'd0 : regs_q[src_b_s];

  // ALU and OPq overflow detection
  always_comb begin
    val_e_s = 64'd0;
    ovf_s   = 1'b0;
    case (icode_s)
      I_CMOV:           val_e_s = val_a_s;
      I_IRMOV:          val_e_s = valc_s;
      I_RMMOV, I_MRMOV: val_e_s = val_b_s + valc_s;
      I_OPQ: begin
        case (ifun_s)
          4'h0: begin
            val_e_s = val_b_s + val_a_s;
            ovf_s   = (val_a_s[63] == val_b_s[63]) && (val_e_s[63] != val_b_s[63]);
          end
          4'h1: begin
            val_e_s = val_b_s - val_a_s;
            ovf_s   = (val_a_s[63] != val_b_s[63]) && (val_e_s[63] != val_b_s[63]);
          end
          4'h2:    val_e_s = val_b_s & val_a_s;
          4'h3:    val_e_s = val_b_s ^ val_a_s;
          default: val_e_s = 64'd0;
        endcase
      end
      I_CALL, I_PUSH:   val_e_s = val_b_s - 64'd8;
      I_RET, I_POP:     val_e_s = val_b_s + 64'd8;
      default:          val_e_s = 64'd0;
    endcase
  end

  assign zf_s = (val_e_s == 64'd0);
  assign sf_s = val_e_s[63];

  // Branch / conditional-move condition from the stored codes {ZF,SF,OF}
  always_comb begin
    case (ifun_s)
      4'h0:    cond_s = 1'b1;
      4'h1:    cond_s = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'h2:    cond_s = cc_q[1] ^ cc_q[0];
      4'h3:    cond_s = cc_q[2];
      4'h4:    cond_s = ~cc_q[2];
      4'h5:    cond_s = ~(cc_q[1] ^ cc_q[0]);
      4'h6:    cond_s = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default: cond_s = 1'b0;
    endcase
    if ((icode_s != I_CMOV) && (icode_s != I_JXX)) begin
      cond_s = 1'b0;
    end else begin
      cond_s = cond_s;
    end
  end

  // Write-back destinations
  always_comb begin
    case (icode_s)
      I_IRMOV, I_OPQ:                dst_e_s = rb_s;
      I_CMOV:                        dst_e_s = cond_s ? rb_s : RNONE;
      I_CALL, I_RET, I_PUSH, I_POP:  dst_e_s = RSP;
      default:                       dst_e_s = RNONE;
    endcase
    case (icode_s)
      I_MRMOV, I_POP: dst_m_s = ra_s;
      default:        dst_m_s = RNONE;
    endcase
  end

  assign wb_ok_s = valid_s && (icode_s != I_HALT) && !imem_err_s;

  // Next register file: M write takes priority over E on the same register
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = (wb_ok_s && (dst_m_s == 4'(i))) ? bus.valM :
                  (wb_ok_s && (dst_e_s == 4'(i))) ? val_e_s  : regs_q[i];
    end
  end

  assign cc_d = ((icode_s == I_OPQ) && valid_s) ? {zf_s, sf_s, ovf_s} : cc_q;

  // Architectural state: register file and condition codes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= 64'd0;
      end
      cc_q <= 3'b100;
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cc_q <= cc_d;
    end
  end

  // Flatten the register file for observation
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_flat_s[64*i +: 64] = regs_q[i];
    end
  end

  assign bus.icode       = icode_s;
  assign bus.ifun        = ifun_s;
  assign bus.rA          = ra_s;
  assign bus.rB          = rb_s;
  assign bus.valC        = valc_s;
  assign bus.valP        = bus.PC + {60'd0, len_s};
  assign bus.instr_valid = valid_s;
  assign bus.imem_error  = imem_err_s;
  assign bus.hlt         = (icode_s == I_HALT);
  assign bus.valA        = val_a_s;
  assign bus.valB        = val_b_s;
  assign bus.valE        = val_e_s;
  assign bus.cond        = cond_s;
  assign bus.overflow    = ovf_s;
  assign bus.cc          = cc_q;
  assign bus.regs_flat   = regs_flat_s;

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Scoreboard bench for y86_fetch_decode_execute: the driver pushes hand-computed
// expectations into a queue, the monitor pops and compares on the falling edge.
module tb_y86_fetch_decode_execute;
  localparam int          IMEM_BYTES = 1024;
  localparam logic [63:0] PARK       = 64'h0000_0000_FFFF_0000;

  localparam int S_ICODE = 0, S_IFUN = 1, S_RA = 2, S_RB = 3, S_VALC = 4, S_VALP = 5,
                 S_VALE = 6, S_VALID = 7, S_IMERR = 8, S_HLT = 9, S_COND = 10,
                 S_OVF = 11, S_CC = 12, S_REG = 13, S_REGZ = 14, S_VALA = 15, S_VALB = 16;

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_fetch_decode_execute_if bus();

  y86_fetch_decode_execute #(.IMEM_BYTES(IMEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] mon_act;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [63:0] actual(input int sel, input int idx);
    case (sel)
      S_ICODE: return {60'd0, bus.icode};
      S_IFUN:  return {60'd0, bus.ifun};
      S_RA:    return {60'd0, bus.rA};
      S_RB:    return {60'd0, bus.rB};
      S_VALC:  return bus.valC;
      S_VALP:  return bus.valP;
      S_VALE:  return bus.valE;
      S_VALID: return {63'd0, bus.instr_valid};
      S_IMERR: return {63'd0, bus.imem_error};
      S_HLT:   return {63'd0, bus.hlt};
      S_COND:  return {63'd0, bus.cond};
      S_OVF:   return {63'd0, bus.overflow};
      S_CC:    return {61'd0, bus.cc};
      S_REG:   return bus.regs_flat[64*idx +: 64];
      S_REGZ:  return {63'd0, |bus.regs_flat};
      S_VALA:  return bus.valA;
      S_VALB:  return bus.valB;
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  task automatic expect_v(input string n, input int sel, input logic [63:0] e);
    exp_t x;
    x.name = n; x.sel = sel; x.idx = 0; x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic expect_reg(input string n, input int idx, input logic [63:0] e);
    exp_t x;
    x.name = n; x.sel = S_REG; x.idx = idx; x.exp = e;
    sb_q.push_back(x);
  endtask

  // Monitor: compare every pending expectation away from the active edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = actual(mon_e.sel, mon_e.idx);
      checks++;
      if (mon_act !== mon_e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = d;
    @(posedge clk);
    #1;
    bus.imem_we = 1'b0;
  endtask

  task automatic wr_irmov(input logic [63:0] a, input logic [3:0] rb, input logic [63:0] v);
    wr(a, 8'h30);
    wr(a + 64'd1, {4'hF, rb});
    for (int k = 0; k < 8; k++) wr(a + 64'd2 + 64'(k), v[8*k +: 8]);
  endtask

  task automatic wr_jxx(input logic [63:0] a, input logic [7:0] op);
    wr(a, op);
    for (int k = 1; k < 9; k++) wr(a + 64'(k), 8'h00);
  endtask

  task automatic set_pc(input logic [63:0] pc, input logic [63:0] vm);
    bus.PC   = pc;
    bus.valM = vm;
  endtask

  // Let the instruction at PC commit, then park PC where nothing is written
  task automatic tick();
    @(posedge clk);
    #1;
    bus.PC = PARK;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = 64'd0;
    bus.imem_wdata = 8'h00;
    bus.PC         = PARK;
    bus.valM       = 64'd0;

    // Program image, loaded while the core is held in reset
    wr(64'h00, 8'h10);
    wr_irmov(64'h10, 4'h2, 64'd10);
    wr_irmov(64'h20, 4'h3, 64'd3);
    wr(64'h30, 8'h61); wr(64'h31, 8'h23);
    wr_jxx(64'h40, 8'h72);
    wr_jxx(64'h50, 8'h71);
    wr_jxx(64'h60, 8'h73);
    wr_irmov(64'h70, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF);
    wr_irmov(64'h80, 4'h1, 64'd1);
    wr(64'h90, 8'h60); wr(64'h91, 8'h01);
    wr_irmov(64'hA0, 4'h4, 64'h100);
    wr(64'hB0, 8'hA0); wr(64'hB1, 8'h2F);
    wr(64'hC0, 8'hB0); wr(64'hC1, 8'h4F);
    wr(64'hD0, 8'h00);
    wr(64'hE0, 8'hC0);
    wr(64'(IMEM_BYTES - 2), 8'h30); wr(64'(IMEM_BYTES - 1), 8'hF2);

    rst_n = 1'b1;
    expect_v("reset_regs_zero", S_REGZ, 64'd0);
    expect_v("reset_cc", S_CC, 64'd4);

    set_pc(64'h00, 64'd0);
    expect_v("nop_icode", S_ICODE, 64'd1);
    expect_v("nop_valP", S_VALP, 64'd1);
    expect_v("nop_hlt", S_HLT, 64'd0);
    tick();

    set_pc(64'h10, 64'd0);
    expect_v("irmov_icode", S_ICODE, 64'd3);
    expect_v("irmov_rA", S_RA, 64'hF);
    expect_v("irmov_rB", S_RB, 64'd2);
    expect_v("irmov_valC", S_VALC, 64'd10);
    expect_v("irmov_valP", S_VALP, 64'h1A);
    expect_v("irmov_valE", S_VALE, 64'd10);
    expect_v("irmov_valid", S_VALID, 64'd1);
    expect_v("irmov_imerr", S_IMERR, 64'd0);
    tick();
    expect_reg("irmov_reg2", 2, 64'd10);

    set_pc(64'h20, 64'd0);
    tick();
    expect_reg("irmov_reg3", 3, 64'd3);

    set_pc(64'h30, 64'd0);
    expect_v("sub_ifun", S_IFUN, 64'd1);
    expect_v("sub_valA", S_VALA, 64'd10);
    expect_v("sub_valB", S_VALB, 64'd3);
    expect_v("sub_valE", S_VALE, 64'hFFFF_FFFF_FFFF_FFF9);
    expect_v("sub_ovf", S_OVF, 64'd0);
    tick();
    expect_reg("sub_reg3", 3, 64'hFFFF_FFFF_FFFF_FFF9);
    expect_v("sub_cc", S_CC, 64'b010);

    set_pc(64'h40, 64'd0);
    expect_v("jl_cond", S_COND, 64'd1);
    expect_v("jl_valP", S_VALP, 64'h49);
    tick();
    set_pc(64'h50, 64'd0);
    expect_v("jle_cond", S_COND, 64'd1);
    tick();
    set_pc(64'h60, 64'd0);
    expect_v("je_cond", S_COND, 64'd0);
    tick();

    set_pc(64'h70, 64'd0);
    tick();
    set_pc(64'h80, 64'd0);
    tick();
    expect_reg("irmov_reg0", 0, 64'h7FFF_FFFF_FFFF_FFFF);

    set_pc(64'h90, 64'd0);
    expect_v("add_valE", S_VALE, 64'h8000_0000_0000_0000);
    expect_v("add_ovf", S_OVF, 64'd1);
    tick();
    expect_reg("add_reg1", 1, 64'h8000_0000_0000_0000);
    expect_v("add_cc", S_CC, 64'b011);

    set_pc(64'hA0, 64'd0);
    tick();
    set_pc(64'hB0, 64'd0);
    expect_v("push_valA", S_VALA, 64'd10);
    expect_v("push_valB", S_VALB, 64'h100);
    expect_v("push_valE", S_VALE, 64'hF8);
    tick();
    expect_reg("push_rsp", 4, 64'hF8);

    set_pc(64'hC0, 64'h55);
    expect_v("pop_valE", S_VALE, 64'h100);
    tick();
    expect_reg("pop_rsp", 4, 64'h55);

    set_pc(64'hD0, 64'd0);
    expect_v("halt_hlt", S_HLT, 64'd1);
    tick();
    expect_reg("halt_rsp", 4, 64'h55);

    set_pc(64'hE0, 64'd0);
    expect_v("bad_valid", S_VALID, 64'd0);
    expect_v("bad_valP", S_VALP, 64'hE1);
    tick();

    set_pc(64'(IMEM_BYTES - 2), 64'd0);
    expect_v("oob_imerr", S_IMERR, 64'd1);
    expect_v("oob_icode", S_ICODE, 64'd3);
    tick();
    expect_reg("oob_reg2", 2, 64'd10);
    expect_reg("oob_reg3", 3, 64'hFFFF_FFFF_FFFF_FFF9);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
